spi_rx_deserialiser: RTL and testbench
======================================

Name: spi_rx_deserialiser

Overview:
- SPI target-side receiver: samples an externally driven CS/SCK/MOSI bus (SPI mode 0, MSB first) in the i_Clock domain and deserialises fixed-length frames into a parallel word.
- Produces a one-cycle valid strobe per complete frame and flags malformed frames.
- Sits on the HSOSC 48 MHz domain beside the DAC SPI output path, receiving words from the MCU/host for forwarding to the DAC data register.

Parameters:
- DATA_WIDTH, 24, bits per frame; also the width of o_Data.
- SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).

Ports:
- i_Clock  input  1  system clock, 48 MHz.
- i_Reset  input  1  synchronous, active-high reset.
- i_SPI_CS  input  1  chip select, active low, asynchronous to i_Clock.
- i_SPI_Clock  input  1  SPI clock, idle low, asynchronous.
- i_SPI_Data  input  1  MOSI, asynchronous.
- o_Data  output  DATA_WIDTH  last complete received word.
- o_Valid  output  1  one-cycle strobe; o_Data updated in the same cycle.
- o_Frame_Err  output  1  one-cycle strobe on a short or over-length frame.
- o_Busy  output  1  high while a frame is in progress (RECV or HOLD).

Behaviour:
- Reset: o_Data=0, o_Valid=0, o_Frame_Err=0, o_Busy=0, state=IDLE, bit counter=0, armed=0.
- Reset values of the synchroniser flops: CS=1, SCK=0, MOSI=0. Reset is sampled on the i_Clock rising edge only.
- Each input passes through SYNC_STAGES flops. Edges are detected by comparing the synchronised value with a one-cycle-delayed copy.
- SCK constraint: high and low phases must each be at least 2 i_Clock periods (SCK ≤ 12 MHz at 48 MHz). Faster SCK is unsupported and unchecked.
- Arming: armed is set on any cycle where synchronised CS=1. A CS falling edge is ignored unless armed=1. This prevents a frame from starting mid-transfer after reset.
- State IDLE:
  - On a CS falling edge with armed=1: clear the shift register and bit counter, then go to RECV.
  - SCK edges are ignored.
- State RECV:
  - On each synchronised SCK rising edge, shift synchronised MOSI into the LSB (MSB first overall) and increment the counter.
  - On the edge that makes count==DATA_WIDTH, load o_Data with the full word (including this bit) and assert o_Valid for one cycle, in the same registered update. Then go to HOLD.
  - Latency: o_Valid is high on the (SYNC_STAGES+2)th i_Clock rising edge after the final SCK rising edge is first sampled.
  - CS rising edge with count<DATA_WIDTH: pulse o_Frame_Err for one cycle, leave o_Data unchanged, go to IDLE.
  - A CS rising edge coincident with the final SCK edge is not possible given the synchroniser ordering. The SCK edge is processed first.
- State HOLD:
  - An SCK rising edge sets an internal overrun flag. No shifting occurs.
  - CS rising edge: pulse o_Frame_Err if overrun is set, clear overrun, go to IDLE.
- o_Busy = (state != IDLE).
- SCK falling edges are never used for sampling.
- o_Valid and o_Frame_Err are never high in the same cycle.
- Back-to-back frames require CS high for at least SYNC_STAGES+2 i_Clock cycles.
- Reset mid-frame: the state machine returns to IDLE and no strobes are issued. If CS is still low at reset release, the remaining bits of that frame are ignored until CS is seen high.
- No internal buffering: the consumer must take o_Data on o_Valid. o_Data holds its value until the next valid frame.

Optional Feature:
- Macro SPI_RX_FRAME_COUNT_EN.
- Defined: adds port o_Frame_Count (output, 16 bits, reset 0). It increments on every o_Valid and wraps from 16'hFFFF to 0. Error frames do not increment it.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Frame 24'hA5C3F0 at SCK 6 MHz, CS low→24 edges→CS high -> exactly one o_Valid pulse, o_Data=24'hA5C3F0, o_Frame_Err never high, o_Busy falls after CS high.
- Valid frame 24'h123456, then a 23-bit frame -> o_Frame_Err one pulse after the CS rise, no o_Valid, o_Data stays 24'h123456.
- 25 SCK edges, first 24 bits = 24'h00FF00 -> o_Valid after the 24th edge with o_Data=24'h00FF00, then o_Frame_Err one pulse after the CS rise.
- CS low, 10 bits, i_Reset high 3 cycles, 14 more bits, CS high, then frame 24'h000001 -> no strobes for the interrupted frame; the next frame gives o_Valid with o_Data=24'h000001.
- Back-to-back 24'h123456 then 24'hFEDCBA, CS high for 4 i_Clock cycles between -> two o_Valid pulses with the correct data in order, no errors.
- With SPI_RX_FRAME_COUNT_EN: 3 good frames plus 1 short frame -> o_Frame_Count=3. After preloading the counter to 16'hFFFF via force, one good frame -> 0.

Source files
------------

// File: rtl/spi_rx_deserialiser.sv
// SPI mode 0 target receiver: synchronises CS/SCK/MOSI into i_Clock and deserialises MSB-first frames.
// Optional macro SPI_RX_FRAME_COUNT_EN adds a 16-bit wrapping count of good frames on o_Frame_Count.
module spi_rx_deserialiser #(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SPI_CS,
    input  logic                  i_SPI_Clock,
    input  logic                  i_SPI_Data,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    output logic                  o_Frame_Err,
    output logic                  o_Busy
`ifdef SPI_RX_FRAME_COUNT_EN
    ,
    output logic [15:0]           o_Frame_Count
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
    logic [SYNC_STAGES:0]    fill_q;
    logic                    cs_prev_q, sck_prev_q;
    logic                    cs_fall_q, cs_rise_q, sck_rise_q, mosi_q;
    logic                    armed_q;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overrun_q, overrun_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    cs_s, sck_s, mosi_s;
    logic                    sync_ok;

    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    // The synchroniser's reset value of CS=1 is not evidence of a real idle bus; only arm once it has refilled.
    assign sync_ok = fill_q[SYNC_STAGES];

    // NOTE: every flop here uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sck_rise_q  <= 1'b0;
            mosi_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clock};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_Data};
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            cs_fall_q   <= cs_prev_q & ~cs_s;
            cs_rise_q   <= ~cs_prev_q & cs_s;
            sck_rise_q  <= ~sck_prev_q & sck_s;
            mosi_q      <= mosi_s;
            armed_q     <= armed_q | (cs_s & sync_ok);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each always_comb assigns a default to every output first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cs_fall_q && armed_q) state_d = ST_RECV;
            ST_RECV: begin
                if (sck_rise_q) begin
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) state_d = ST_HOLD;
                end else if (cs_rise_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: if (cs_rise_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        data_d    = data_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall_q && armed_q) begin
                    shift_d   = '0;
                    count_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            ST_RECV: begin
                // A final SCK edge wins over a coincident CS rise; the frame is then complete.
                if (sck_rise_q) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_q};
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                        data_d  = {shift_q[DATA_WIDTH-2:0], mosi_q};
                        valid_d = 1'b1;
                    end
                end else if (cs_rise_q) begin
                    err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (sck_rise_q) overrun_d = 1'b1;
                if (cs_rise_q) begin
                    err_d     = overrun_q;
                    overrun_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            shift_q   <= '0;
            data_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            data_q    <= data_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        o_Data      = data_q;
        o_Valid     = valid_q;
        o_Frame_Err = err_q;
        o_Busy      = (state_q != ST_IDLE);
    end

`ifdef SPI_RX_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            frame_count_q <= '0;
        end else if (valid_d) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign o_Frame_Count = frame_count_q;
`endif

endmodule

// File: tb/tb_spi_rx_deserialiser.sv
// Self-checking bench for spi_rx_deserialiser: directed test-plan frames plus random-length frames
// checked against a frame-level model (good / short / over-length rules).
module tb_spi_rx_deserialiser;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, sck, mosi;
    logic [DW-1:0] o_data;
    logic          o_valid, o_err, o_busy;
`ifdef SPI_RX_FRAME_COUNT_EN
    logic [15:0]   o_count;
`endif

    spi_rx_deserialiser #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_SPI_CS    (cs),
        .i_SPI_Clock (sck),
        .i_SPI_Data  (mosi),
        .o_Data      (o_data),
        .o_Valid     (o_valid),
        .o_Frame_Err (o_err),
        .o_Busy      (o_busy)
`ifdef SPI_RX_FRAME_COUNT_EN
        ,
        .o_Frame_Count (o_count)
`endif
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            valid_seen = 0;
    int            err_seen = 0;
    int            overlap_seen = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] model_data = '0;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            valid_seen++;
            got_q.push_back(o_data);
        end
        if (o_err === 1'b1) err_seen++;
        if (o_valid === 1'b1 && o_err === 1'b1) overlap_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCK at 1/8 of i_Clock: 4 cycles low with MOSI set up, 4 cycles high.
    task automatic send_bits(input logic [31:0] val, input int nbits, input bit busy_chk);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            wait_clk(4);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            if (busy_chk && i == nbits / 2) check("busy_mid_frame", 32'(o_busy), 32'd1);
        end
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits, input int gap, input bit busy_chk);
        cs = 1'b0;
        wait_clk(4);
        send_bits(val, nbits, busy_chk);
        wait_clk(4);
        cs = 1'b1;
        wait_clk(gap);
    endtask

    // Frame-level model: a frame of at least DW bits yields its first DW bits as a word;
    // any length other than DW is reported as a framing error once CS rises.
    task automatic run_frame(input string tag, input logic [31:0] val, input int nbits, input int gap);
        int            v0, e0, exp_v, exp_e;
        logic [DW-1:0] exp_word;
        v0       = valid_seen;
        e0       = err_seen;
        exp_v    = (nbits >= DW) ? 1 : 0;
        exp_e    = (nbits != DW) ? 1 : 0;
        exp_word = DW'(val >> ((nbits >= DW) ? (nbits - DW) : 0));
        send_frame(val, nbits, gap, 1'b0);
        check({tag, "_valid_cnt"}, 32'(valid_seen - v0), 32'(exp_v));
        check({tag, "_err_cnt"}, 32'(err_seen - e0), 32'(exp_e));
        if (exp_v == 1) begin
            model_data = exp_word;
            if (got_q.size() > 0) check({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_word));
            else check({tag, "_word_missing"}, 32'(got_q.size()), 32'd1);
        end
        check({tag, "_o_data_hold"}, 32'(o_data), 32'(model_data));
        check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int            v0, e0, len, sel;
        logic [31:0]   rnd;

        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        wait_clk(3);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_err", 32'(o_err), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        wait_clk(8);

        // Directed frame with a mid-frame busy probe.
        v0 = valid_seen; e0 = err_seen;
        send_frame(32'hA5C3F0, DW, 8, 1'b1);
        check("a5_valid_cnt", 32'(valid_seen - v0), 32'd1);
        check("a5_err_cnt", 32'(err_seen - e0), 32'd0);
        check("a5_word", 32'(got_q.pop_front()), 32'hA5C3F0);
        check("a5_busy_after", 32'(o_busy), 32'd0);
        model_data = 24'hA5C3F0;

        run_frame("good_123456", 32'h123456, DW, 8);
        run_frame("short_23", 32'h2AAAAA, 23, 8);
        run_frame("long_25", {7'd0, 24'h00FF00, 1'b1}, 25, 8);

        // Reset in the middle of a frame; the tail must be ignored until CS is seen high.
        v0 = valid_seen; e0 = err_seen;
        cs = 1'b0;
        wait_clk(4);
        send_bits(32'h3FF, 10, 1'b0);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        send_bits(32'h3FFF, 14, 1'b0);
        check("rst_tail_busy", 32'(o_busy), 32'd0);
        wait_clk(4);
        cs = 1'b1;
        wait_clk(8);
        check("rst_mid_valid_cnt", 32'(valid_seen - v0), 32'd0);
        check("rst_mid_err_cnt", 32'(err_seen - e0), 32'd0);
        check("rst_mid_data", 32'(o_data), 32'd0);
        model_data = '0;
        run_frame("after_rst", 32'h000001, DW, 8);

        // Back-to-back with the minimum CS-high gap.
        v0 = valid_seen; e0 = err_seen;
        send_frame(32'h123456, DW, 4, 1'b0);
        send_frame(32'hFEDCBA, DW, 8, 1'b0);
        check("b2b_valid_cnt", 32'(valid_seen - v0), 32'd2);
        check("b2b_err_cnt", 32'(err_seen - e0), 32'd0);
        check("b2b_word0", 32'(got_q.pop_front()), 32'h123456);
        check("b2b_word1", 32'(got_q.pop_front()), 32'hFEDCBA);
        model_data = 24'hFEDCBA;

        // Random frames: mostly good, some short, some over-length.
        for (int k = 0; k < 10; k++) begin
            sel = int'($urandom_range(0, 3));
            if (sel <= 1) len = DW;
            else if (sel == 2) len = int'($urandom_range(1, DW - 1));
            else len = int'($urandom_range(DW + 1, DW + 3));
            rnd = $urandom;
            if (len < 32) rnd = rnd & ((32'd1 << len) - 32'd1);
            run_frame($sformatf("rnd%0d_len%0d", k, len), rnd, len, 8);
        end

`ifdef SPI_RX_FRAME_COUNT_EN
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        check("cnt_reset", 32'(o_count), 32'd0);
        model_data = '0;
        run_frame("cnt_g0", 32'h111111, DW, 8);
        run_frame("cnt_g1", 32'h222222, DW, 8);
        run_frame("cnt_short", 32'h0333, 12, 8);
        run_frame("cnt_g2", 32'h444444, DW, 8);
        check("cnt_three", 32'(o_count), 32'd3);
        force dut.frame_count_q = 16'hFFFF;
        wait_clk(1);
        release dut.frame_count_q;
        wait_clk(1);
        run_frame("cnt_wrap_frame", 32'h555555, DW, 8);
        check("cnt_wrap", 32'(o_count), 32'd0);
`endif

        check("no_valid_err_overlap", 32'(overlap_seen), 32'd0);
        check("no_stray_words", 32'(got_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
